// File: rtl/hv_bundle_accumulator.sv
// Saturating bundle accumulator for the HD accelerator: sums NUM_SAMPLES unsigned
// element values through a prefix carry-lookahead adder and hands the result downstream.

module carry_lookahead_adder #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] add1,
    input  logic [WIDTH-1:0] add2,
    output logic [WIDTH:0]   result
);
    localparam int LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // Kogge-Stone prefix tree: level L holds group generate/propagate spanning 2**L bits.
    logic [LEVELS:0][WIDTH-1:0] gen;
    logic [LEVELS:0][WIDTH-1:0] prop;
    logic [WIDTH:0]             carry;

    always_comb begin
        gen     = '0;
        prop    = '0;
        gen[0]  = add1 & add2;
        prop[0] = add1 ^ add2;
        for (int l = 0; l < LEVELS; l++) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (i >= (1 << l)) begin
                    gen[l+1][i]  = gen[l][i] | (prop[l][i] & gen[l][i - (1 << l)]);
                    prop[l+1][i] = prop[l][i] & prop[l][i - (1 << l)];
                end else begin
                    gen[l+1][i]  = gen[l][i];
                    prop[l+1][i] = prop[l][i];
                end
            end
        end
        carry    = '0;
        carry[0] = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            carry[i+1] = gen[LEVELS][i];
        end
        result = {carry[WIDTH], prop[0] ^ carry[WIDTH-1:0]};
    end
endmodule

module hv_bundle_accumulator #(
    parameter int WIDTH       = 8,
    parameter int ACC_WIDTH   = 16,
    parameter int NUM_SAMPLES = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_flush,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [WIDTH-1:0]     i_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [ACC_WIDTH-1:0] o_sum,
    output logic                 o_overflow
);
    localparam int CW = $clog2(NUM_SAMPLES + 1);
    localparam logic [CW-1:0] LAST = CW'(NUM_SAMPLES - 1);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // o_ready depends on state only, o_valid/o_sum/o_overflow are held until taken.
    typedef enum logic {ACCUM = 1'b0, DONE = 1'b1} state_t;

    state_t               state;
    logic [ACC_WIDTH-1:0] acc;
    logic [CW-1:0]        count;
    logic                 ovf;
    logic [ACC_WIDTH:0]   add_result;
    logic                 carry_out;
    logic [ACC_WIDTH-1:0] sat_sum;
    logic                 accept;

    carry_lookahead_adder #(.WIDTH(ACC_WIDTH)) u_adder (
        .add1   (acc),
        .add2   (ACC_WIDTH'(i_data)),
        .result (add_result)
    );

    assign carry_out = add_result[ACC_WIDTH];
    assign sat_sum   = carry_out ? '1 : add_result[ACC_WIDTH-1:0];
    assign o_ready   = (state == ACCUM);
    assign accept    = i_valid & o_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= ACCUM;
            acc        <= '0;
            count      <= '0;
            ovf        <= 1'b0;
            o_valid    <= 1'b0;
            o_sum      <= '0;
            o_overflow <= 1'b0;
        end else if (i_flush) begin
            // Abort drops the partial bundle but keeps the last published result.
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
            if (state == DONE) begin
                o_valid <= 1'b0;
                state   <= ACCUM;
            end
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        if (count == LAST) begin
                            o_sum      <= sat_sum;
                            o_overflow <= ovf | carry_out;
                            o_valid    <= 1'b1;
                            state      <= DONE;
                            acc        <= '0;
                            count      <= '0;
                            ovf        <= 1'b0;
                        end else begin
                            acc   <= sat_sum;
                            count <= count + CW'(1);
                            ovf   <= ovf | carry_out;
                        end
                    end
                end
                DONE: begin
                    if (i_ready && o_valid) begin
                        o_valid <= 1'b0;
                        state   <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end
endmodule

// File: doc/hv_bundle_accumulator.md
Name: hv_bundle_accumulator

Overview:
Sequential bundling stage that feeds sample values into a carry_lookahead_adder and consumes its sum. It accumulates NUM_SAMPLES unsigned hypervector element values into one saturating bundle sum. The block sits between the encoder element stream and the majority/threshold logic of the HD accelerator. It uses valid/ready handshakes on both sides and instantiates carry_lookahead_adder #(ACC_WIDTH) as its only adder.

Parameters:
WIDTH, 8, bit width of each input element (unsigned)
ACC_WIDTH, 16, accumulator/result width; must be >= WIDTH
NUM_SAMPLES, 4, samples bundled per result; must be >= 1

Ports:
i_clk  input  1  clock; all state updates on rising edge
i_rst  input  1  synchronous, active-high reset
i_flush  input  1  synchronous abort of current bundle
i_valid  input  1  input sample valid
o_ready  output  1  block can accept a sample
i_data  input  WIDTH  input sample value
o_valid  output  1  bundle result valid
i_ready  input  1  downstream accepts result
o_sum  output  ACC_WIDTH  bundled sum (saturated)
o_overflow  output  1  bundle saturated at least once

Behaviour:
- States: ACCUM and DONE. Reset state is ACCUM.
- Reset values: acc=0, count=0, o_valid=0, o_sum=0, o_overflow=0, o_ready=1.
- Adder: add1=acc, add2={zero-extend i_data to ACC_WIDTH}. Result bit [ACC_WIDTH] is the carry out.
- Saturation: if carry out=1, acc_next = all ones and the sticky ovf flag is set. If acc is already all ones, it stays all ones.
- Input accept: a sample is accepted when i_valid & o_ready at the clock edge.
- o_ready = 1 in ACCUM and 0 in DONE. Combinational from state only, with no dependence on i_valid.
- ACCUM, on accept, with count < NUM_SAMPLES-1: acc <= sat_sum; count++.
- ACCUM, on accept, with count == NUM_SAMPLES-1:
  - o_sum <= sat_sum; o_overflow <= ovf | carry_out; o_valid <= 1.
  - Go to DONE; acc, count and ovf clear.
  - Latency: result is visible the cycle after the final sample is accepted.
- ACCUM with no accept: all state holds.
- DONE: o_sum, o_overflow and o_valid hold stable until i_ready=1 with o_valid=1. On that edge: o_valid <= 0, go to ACCUM, and o_ready is 1 the following cycle.
  - One bubble cycle between bundles is required.
  - i_valid in DONE is ignored, since o_ready=0.
- i_flush (ACCUM): acc, count and ovf clear; any sample presented that cycle is discarded. o_sum and o_overflow keep their last values.
- i_flush (DONE): o_valid <= 0, go to ACCUM; o_sum and o_overflow hold.
- Priority: i_rst > i_flush > handshake.
- Reset mid-bundle: partial sum is lost and all outputs return to reset values next cycle.
- NUM_SAMPLES=1: every accepted sample produces a result immediately the next cycle.
- count width: $clog2(NUM_SAMPLES+1) bits, so it never wraps within a bundle.
- o_sum and o_overflow change only when a bundle completes, or on reset.

Test Plan:
- WIDTH=8, ACC_WIDTH=16, N=4; samples 10,20,30,40 back-to-back with i_ready=1 -> o_valid one cycle after 40; o_sum=100, o_overflow=0; o_ready low for one cycle, then high.
- WIDTH=8, ACC_WIDTH=9, N=4; samples 255,255,255,255 -> o_sum=511, o_overflow=1. Next bundle 1,1,1,1 -> o_sum=4, o_overflow=0 (sticky flag cleared per bundle).
- Backpressure: i_ready=0 for 5 cycles after the result -> o_valid, o_sum and o_overflow stable for all 5 cycles. i_valid held high meanwhile is not accepted; the next bundle starts only after the i_ready handshake.
- Gapped input: samples 7,_,_,8,_,9,10 with i_valid toggling -> o_sum=34; only valid cycles are counted.
- Flush after 2 samples (5,6), then samples 1,2,3,4 -> o_sum=10, with no contribution from 5 or 6. Flush asserted in DONE -> o_valid drops next cycle and o_sum holds.
- i_rst asserted after 3 of 4 samples, then samples 2,2,2,2 -> all outputs are 0 the cycle after reset; the next result is o_sum=8.
